// File: rtl/maple_frame_decoder.sv
// Maple bus receive framing: decodes start, data and end patterns
// from SDCKA/SDCKB into byte and frame strobes for the packet layer.
module maple_frame_decoder #(
  parameter int TIMEOUT_TICKS = 1000,
  parameter int TMR_W         = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdcka,
  input  logic       sdckb,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_END,
    S_DONE,
    S_ERROR
  } state_t;

  logic r_a_m;
  logic r_a_s;
  logic r_a_q;
  logic r_b_m;
  logic r_b_s;
  logic r_b_q;

  state_t     r_state;
  logic [2:0] r_edge_cnt;
  logic [2:0] r_bit_cnt;
  logic       r_phase;
  logic [6:0] r_shift;
  logic [TMR_W-1:0] r_tmr;
  logic [7:0] r_data;
  logic       r_dv;
  logic       r_fs;
  logic       r_fd;
  logic       r_fe;

  logic w_fall_a;
  logic w_rise_a;
  logic w_fall_b;
  logic w_rise_b;
  logic w_any_edge;
  logic w_both_fall;
  logic w_busy;
  logic w_tmo;

  state_t     w_state_nx;
  logic [2:0] w_edge_cnt_nx;
  logic [2:0] w_bit_cnt_nx;
  logic       w_phase_nx;
  logic [6:0] w_shift_nx;
  logic [7:0] w_data_nx;
  logic       w_dv_nx;
  logic       w_fs_nx;
  logic       w_fd_nx;
  logic       w_fe_nx;
  logic       w_shift_en;
  logic       w_shift_bit;
  logic [2:0] w_edge_inc;

  // Two-flop synchroniser plus one history flop per line
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a_m <= 1'b1;
      r_a_s <= 1'b1;
      r_a_q <= 1'b1;
      r_b_m <= 1'b1;
      r_b_s <= 1'b1;
      r_b_q <= 1'b1;
    end else begin
      r_a_m <= sdcka;
      r_a_s <= r_a_m;
      r_a_q <= r_a_s;
      r_b_m <= sdckb;
      r_b_s <= r_b_m;
      r_b_q <= r_b_s;
    end
  end

  assign w_fall_a    = r_a_q & ~r_a_s;
  assign w_rise_a    = ~r_a_q & r_a_s;
  assign w_fall_b    = r_b_q & ~r_b_s;
  assign w_rise_b    = ~r_b_q & r_b_s;
  assign w_any_edge  = w_fall_a | w_rise_a | w_fall_b | w_rise_b;
  assign w_both_fall = w_fall_a & w_fall_b;

  assign w_busy = (r_state == S_START) |
                  (r_state == S_DATA)  |
                  (r_state == S_END);

  assign w_tmo = ~w_any_edge &
                 (r_tmr == TMR_W'(TIMEOUT_TICKS - 1));

  assign w_edge_inc = (r_edge_cnt == 3'd7) ?
                      r_edge_cnt : r_edge_cnt + 3'd1;

  // Idle-line timer: runs only inside a frame, cleared by any edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tmr <= '0;
    end else if (!w_busy || w_any_edge) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  // Next-state, counters, shifter and strobe decode
  always_comb begin
    w_state_nx    = r_state;
    w_edge_cnt_nx = r_edge_cnt;
    w_bit_cnt_nx  = r_bit_cnt;
    w_phase_nx    = r_phase;
    w_shift_nx    = r_shift;
    w_data_nx     = r_data;
    w_dv_nx       = 1'b0;
    w_fs_nx       = 1'b0;
    w_fd_nx       = 1'b0;
    w_fe_nx       = 1'b0;
    w_shift_en    = 1'b0;
    w_shift_bit   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_fall_a && r_b_s) begin
          w_state_nx    = S_START;
          w_edge_cnt_nx = 3'd0;
        end
      end
      S_START: begin
        if (w_both_fall) begin
          w_state_nx = S_ERROR;
        end else if (w_rise_a) begin
          if (r_edge_cnt == 3'd4) begin
            w_state_nx   = S_DATA;
            w_fs_nx      = 1'b1;
            w_bit_cnt_nx = 3'd0;
            w_phase_nx   = 1'b0;
          end else begin
            w_state_nx = S_ERROR;
          end
        end else if (w_fall_b) begin
          w_edge_cnt_nx = w_edge_inc;
        end
      end
      S_DATA: begin
        if (w_both_fall) begin
          w_state_nx = S_ERROR;
        end else if (!r_phase) begin
          if (w_fall_a) begin
            w_shift_en  = 1'b1;
            w_shift_bit = r_b_s;
            w_phase_nx  = 1'b1;
          end else if (w_fall_b && r_a_s) begin
            w_state_nx    = S_END;
            w_edge_cnt_nx = 3'd0;
          end
        end else begin
          if (w_fall_a) begin
            w_state_nx = S_ERROR;
          end else if (w_fall_b) begin
            w_shift_en  = 1'b1;
            w_shift_bit = r_a_s;
            w_phase_nx  = 1'b0;
          end
        end
      end
      S_END: begin
        if (w_fall_b) begin
          w_state_nx = S_ERROR;
        end else if (w_rise_b) begin
          if (r_edge_cnt == 3'd2 && r_bit_cnt == 3'd0) begin
            w_state_nx = S_DONE;
            w_fd_nx    = 1'b1;
          end else begin
            w_state_nx = S_ERROR;
          end
        end else if (w_fall_a && !r_b_s) begin
          w_edge_cnt_nx = w_edge_inc;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      S_ERROR: begin
        if (r_a_s && r_b_s) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if (w_shift_en) begin
      if (r_bit_cnt == 3'd7) begin
        w_data_nx    = {r_shift, w_shift_bit};
        w_dv_nx      = 1'b1;
        w_bit_cnt_nx = 3'd0;
      end else begin
        w_shift_nx   = {r_shift[5:0], w_shift_bit};
        w_bit_cnt_nx = r_bit_cnt + 3'd1;
      end
    end

    if (w_busy && w_tmo) begin
      w_state_nx = S_ERROR;
    end

    w_fe_nx = (w_state_nx == S_ERROR) && (r_state != S_ERROR);
  end

  // State, datapath and registered strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= 3'd0;
      r_bit_cnt  <= 3'd0;
      r_phase    <= 1'b0;
      r_shift    <= 7'd0;
      r_data     <= 8'd0;
      r_dv       <= 1'b0;
      r_fs       <= 1'b0;
      r_fd       <= 1'b0;
      r_fe       <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_edge_cnt <= w_edge_cnt_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_phase    <= w_phase_nx;
      r_shift    <= w_shift_nx;
      r_data     <= w_data_nx;
      r_dv       <= w_dv_nx;
      r_fs       <= w_fs_nx;
      r_fd       <= w_fd_nx;
      r_fe       <= w_fe_nx;
    end
  end

  assign data_out    = r_data;
  assign data_valid  = r_dv;
  assign frame_start = r_fs;
  assign frame_done  = r_fd;
  assign frame_error = r_fe;
  assign busy        = w_busy;

endmodule
